// File: rtl/axi4_lite_nn_master.sv
// axi4_lite_nn_master: streams NUM_WORDS image words into the NN slave over AXI4-Lite,
// then reads the result register and returns the 4-bit prediction with a done pulse.
module axi4_lite_nn_master #(
    parameter int ADDRESS = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS = 24,
    parameter logic [ADDRESS-1:0] RESULT_ADDR = 32'h60
) (
    input  logic                  ACLK,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            prediction,
    output logic                  error,
    output logic [ADDRESS-1:0]    M_AWADDR,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    output logic [DATA_WIDTH-1:0] M_WDATA,
    output logic [3:0]            M_WSTRB,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    output logic [ADDRESS-1:0]    M_ARADDR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);
    localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WRITE, WRESP, RADDR, RDATA, FINISH} state_t;

    state_t                state, n_state;
    logic [IW-1:0]         idx, n_idx;
    logic [ADDRESS-1:0]    n_awaddr;
    logic [DATA_WIDTH-1:0] n_wdata;
    logic                  n_awvalid, n_wvalid, n_err;
    logic [3:0]            n_pred;
    logic                  unused_rdata;

    assign unused_rdata = ^M_RDATA[DATA_WIDTH-1:4];
    assign M_WSTRB = 4'hF;

    always_comb begin
        n_state   = state;
        n_idx     = idx;
        n_awaddr  = M_AWADDR;
        n_wdata   = M_WDATA;
        n_awvalid = M_AWVALID;
        n_wvalid  = M_WVALID;
        n_pred    = prediction;
        n_err     = error;
        case (state)
            IDLE: if (start) begin
                n_state = FETCH;
                n_idx   = '0;
                n_err   = 1'b0;
            end
            FETCH: if (word_valid && word_ready) begin
                n_state   = WRITE;
                n_wdata   = word_data;
                n_awaddr  = ADDRESS'({idx, 2'b00});
                n_awvalid = 1'b1;
                n_wvalid  = 1'b1;
            end
            // each valid retires on its own handshake; leave once both are gone
            WRITE: begin
                n_awvalid = M_AWVALID && !M_AWREADY;
                n_wvalid  = M_WVALID && !M_WREADY;
                n_state   = (!n_awvalid && !n_wvalid) ? WRESP : WRITE;
            end
            WRESP: if (M_BVALID && M_BREADY) begin
                n_err   = error || (M_BRESP != 2'b00);
                n_state = (idx == LAST) ? RADDR : FETCH;
                n_idx   = (idx == LAST) ? idx : idx + 1'b1;
            end
            RADDR: n_state = (M_ARVALID && M_ARREADY) ? RDATA : RADDR;
            RDATA: if (M_RVALID && M_RREADY) begin
                n_pred  = M_RDATA[3:0];
                n_err   = error || (M_RRESP != 2'b00);
                n_state = FINISH;
            end
            FINISH: n_state = IDLE;
            default: n_state = IDLE;
        endcase
    end

    // handshake strobes are registered from the next state so every output is a flop
    always_ff @(posedge ACLK or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            M_AWADDR   <= '0;
            M_WDATA    <= '0;
            M_AWVALID  <= 1'b0;
            M_WVALID   <= 1'b0;
            M_BREADY   <= 1'b0;
            M_ARADDR   <= '0;
            M_ARVALID  <= 1'b0;
            M_RREADY   <= 1'b0;
            word_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            prediction <= '0;
            error      <= 1'b0;
        end else begin
            state      <= n_state;
            idx        <= n_idx;
            M_AWADDR   <= n_awaddr;
            M_WDATA    <= n_wdata;
            M_AWVALID  <= n_awvalid;
            M_WVALID   <= n_wvalid;
            M_BREADY   <= n_state == WRESP;
            M_ARADDR   <= n_state == RADDR ? RESULT_ADDR : M_ARADDR;
            M_ARVALID  <= n_state == RADDR;
            M_RREADY   <= n_state == RDATA;
            word_ready <= n_state == FETCH;
            busy       <= n_state != IDLE;
            done       <= n_state == FINISH;
            prediction <= n_pred;
            error      <= n_err;
        end
    end
endmodule

// File: tb/tb_axi4_lite_nn_master.sv
// tb_axi4_lite_nn_master: directed bench with a behavioural AXI4-Lite responder and word source.
module tb_axi4_lite_nn_master;
    logic        ACLK = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] word_data;
    logic        word_valid, word_ready, busy, done, error;
    logic [3:0]  prediction;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic [3:0]  M_WSTRB;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [1:0]  M_BRESP, M_RRESP;

    int checks = 0;
    int failures = 0;

    int word_n = 0, stall_cnt = 0, stall_at = -1, stall_len = 10;
    int aw_dly = 0, w_dly = 0, r_dly = 0, err_idx = -1, base = 0;
    int aw_cnt = 0, w_cnt = 0, r_cnt = 0, wr_count = 0, rd_count = 0, stab_err = 0;
    logic [31:0] rdata_v = 32'h0;
    logic [1:0]  rresp_v = 2'b00;
    logic got_aw = 1'b0, got_w = 1'b0, r_pend = 1'b0, hold_aw = 1'b0, hold_w = 1'b0;
    logic [31:0] cur_aw, cur_w, hold_addr, hold_data;
    logic [31:0] log_addr [256];
    logic [31:0] log_data [256];
    logic [3:0]  log_strb [256];
    logic [31:0] ar_log [64];
    int cyc;

    always #5 ACLK = ~ACLK;

    axi4_lite_nn_master dut (
        .ACLK(ACLK), .rst(rst), .start(start), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .busy(busy), .done(done), .prediction(prediction), .error(error),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    assign word_data  = 32'h1000_0000 + word_n;
    assign word_valid = !(word_n == stall_at && stall_cnt < stall_len);
    assign M_AWREADY  = M_AWVALID && aw_cnt >= aw_dly;
    assign M_WREADY   = M_WVALID && w_cnt >= w_dly;
    assign M_ARREADY  = 1'b1;
    assign M_RDATA    = rdata_v;
    assign M_RRESP    = rresp_v;

    always @(posedge ACLK) begin
        if (start && !busy) begin
            word_n    <= 0;
            stall_cnt <= 0;
        end else begin
            if (word_valid && word_ready) word_n <= word_n + 1;
            if (word_ready && !word_valid && word_n == stall_at && stall_cnt < stall_len)
                stall_cnt <= stall_cnt + 1;
        end
    end

    // slave responder: logs completed writes, flags unstable or lingering valids
    always @(posedge ACLK or posedge rst) begin
        if (rst) begin
            got_aw <= 1'b0; got_w <= 1'b0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
            M_BVALID <= 1'b0; M_BRESP <= 2'b00; M_RVALID <= 1'b0; r_pend <= 1'b0;
            hold_aw <= 1'b0; hold_w <= 1'b0;
        end else begin
            if (M_AWVALID && M_AWREADY) begin
                got_aw <= 1'b1; cur_aw <= M_AWADDR; aw_cnt <= 0;
            end else if (M_AWVALID) aw_cnt <= aw_cnt + 1;
            if (M_WVALID && M_WREADY) begin
                got_w <= 1'b1; cur_w <= M_WDATA; w_cnt <= 0;
            end else if (M_WVALID) w_cnt <= w_cnt + 1;
            if (M_BVALID && M_BREADY) M_BVALID <= 1'b0;
            if ((got_aw || (M_AWVALID && M_AWREADY)) && (got_w || (M_WVALID && M_WREADY))) begin
                log_addr[wr_count[7:0]] <= (M_AWVALID && M_AWREADY) ? M_AWADDR : cur_aw;
                log_data[wr_count[7:0]] <= (M_WVALID && M_WREADY) ? M_WDATA : cur_w;
                log_strb[wr_count[7:0]] <= M_WSTRB;
                M_BVALID <= 1'b1;
                M_BRESP  <= (wr_count - base == err_idx) ? 2'b10 : 2'b00;
                wr_count <= wr_count + 1;
                got_aw <= 1'b0; got_w <= 1'b0;
            end
            stab_err <= stab_err + int'(hold_aw && (!M_AWVALID || M_AWADDR != hold_addr))
                                 + int'(hold_w && (!M_WVALID || M_WDATA != hold_data))
                                 + int'(got_aw && M_AWVALID) + int'(got_w && M_WVALID)
                                 + int'(word_ready && M_AWVALID);
            hold_aw <= M_AWVALID && !M_AWREADY; hold_addr <= M_AWADDR;
            hold_w  <= M_WVALID && !M_WREADY;   hold_data <= M_WDATA;
            if (M_RVALID && M_RREADY) M_RVALID <= 1'b0;
            if (M_ARVALID && M_ARREADY) begin
                ar_log[rd_count[5:0]] <= M_ARADDR;
                rd_count <= rd_count + 1;
                if (r_dly == 0) M_RVALID <= 1'b1;
                else begin r_pend <= 1'b1; r_cnt <= 1; end
            end else if (r_pend) begin
                if (r_cnt >= r_dly) begin M_RVALID <= 1'b1; r_pend <= 1'b0; end
                else r_cnt <= r_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic run(input int mid, output int n);
        base = wr_count;
        start = 1'b1;
        @(posedge ACLK); #1;
        start = 1'b0;
        n = 1;
        chk("start_busy", busy, 1);
        chk("start_err_clr", error, 0);
        while (done !== 1'b1 && n < 3000) begin
            @(posedge ACLK); #1;
            n++;
            start = (n == mid);
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 1);
    endtask

    task automatic after_done();
        @(posedge ACLK); #1;
        chk("done_pulse", done, 0);
        chk("busy_fall", busy, 0);
        chk("wr_total", wr_count - base, 24);
        chk("ar_addr", ar_log[(rd_count - 1) % 64], 32'h60);
        chk("stable", stab_err, 0);
    endtask

    task automatic check_log();
        for (int n = 0; n < 24; n++) begin
            chk($sformatf("wr%0d_addr", n), log_addr[base + n], 4 * n);
            chk($sformatf("wr%0d_data", n), log_data[base + n], 32'h1000_0000 + n);
            chk($sformatf("wr%0d_strb", n), log_strb[base + n], 4'hF);
        end
    endtask

    initial begin
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_ctl", {busy, done, error, word_ready, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}, 0);
        chk("rst_pred", prediction, 0);
        chk("rst_addr", {M_AWADDR, M_ARADDR}, 0);
        chk("rst_wdata", M_WDATA, 0);
        chk("rst_wstrb", M_WSTRB, 4'hF);
        @(negedge ACLK) rst = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;

        rdata_v = 32'hABCD_0007;
        run(0, cyc);
        chk("t1_cycles", cyc, 75);
        chk("t1_pred", prediction, 7);
        chk("t1_err", error, 0);
        after_done();
        check_log();

        w_dly = 3; rdata_v = 32'h9; rresp_v = 2'b10;
        run(0, cyc);
        chk("t2_cycles", cyc, 147);
        chk("t2_pred", prediction, 9);
        chk("t2_rresp_err", error, 1);
        after_done();
        check_log();

        w_dly = 0; rresp_v = 2'b00; err_idx = 5; rdata_v = 32'h2;
        run(0, cyc);
        chk("t3_cycles", cyc, 75);
        chk("t3_pred", prediction, 2);
        chk("t3_bresp_err", error, 1);
        after_done();
        check_log();

        err_idx = -1; stall_at = 12; rdata_v = 32'h5;
        run(30, cyc);
        chk("t4_cycles", cyc, 85);
        chk("t4_pred", prediction, 5);
        chk("t4_err", error, 0);
        after_done();
        check_log();
        stall_at = -1;

        r_dly = 50; rdata_v = 32'h3;
        base = wr_count;
        start = 1'b1;
        @(posedge ACLK); #1;
        start = 1'b0;
        for (int i = 0; i < 200 && M_RREADY !== 1'b1; i++) begin
            @(posedge ACLK); #1;
        end
        chk("t5_rready", M_RREADY, 1);
        repeat (5) @(posedge ACLK);
        #1;
        chk("t5_pred_hold", prediction, 5);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_ctl", {busy, done, error, word_ready, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}, 0);
        chk("t5_rst_pred", prediction, 0);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK) rst = 1'b0;
        @(posedge ACLK); #1;
        r_dly = 0; rdata_v = 32'hC;
        run(0, cyc);
        chk("t6_cycles", cyc, 75);
        chk("t6_pred", prediction, 4'hC);
        chk("t6_first_addr", log_addr[base], 0);
        after_done();
        check_log();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi4_lite_nn_master.md
# axi4_lite_nn_master

AXI4-Lite master that drives the neural-network accelerator slave from the host side. On a start pulse it streams NUM_WORDS image words from a ready/valid source into slave registers 0..NUM_WORDS-1 as single-beat writes. It then reads RESULT_ADDR, which triggers inference in the slave, and returns the 4-bit prediction with a done pulse. It sits between the test/host logic and the axi4_lite_slave port set, with one transaction outstanding at a time.

## Interface
- ADDRESS, 32, AXI address width
- DATA_WIDTH, 32, AXI data width
- NUM_WORDS, 24, image words written per inference
- RESULT_ADDR, 32'h60, byte address of the prediction register (register 24)
- ACLK  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- word_data  in  DATA_WIDTH  image word; word n goes to byte address 4*n
- word_valid  in  1  word_data valid
- word_ready  out  1  word accepted when word_valid && word_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the result is captured
- prediction  out  4  RDATA[3:0] of the result read; held until the next capture
- error  out  1  sticky: any BRESP or RRESP != 2'b00 since the last accepted start
- M_AWADDR, M_AWVALID, M_AWREADY  out/out/in  ADDRESS/1/1  write address channel
- M_WDATA, M_WSTRB, M_WVALID, M_WREADY  out/out/out/in  DATA_WIDTH/4/1/1  write data channel; WSTRB is always 4'hF
- M_BRESP, M_BVALID, M_BREADY  in/in/out  2/1/1  write response channel
- M_ARADDR, M_ARVALID, M_ARREADY  out/out/in  ADDRESS/1/1  read address channel
- M_RDATA, M_RRESP, M_RVALID, M_RREADY  in/in/in/out  DATA_WIDTH/2/1/1  read data channel

## Operation
- States: IDLE, FETCH, WRITE, WRESP, RADDR, RDATA, FINISH.
- IDLE: if start, clear word counter idx and error, then go to FETCH. A start seen in any other state is ignored.
- FETCH: word_ready=1.
  - On a word handshake, latch word_data into M_WDATA and idx<<2 into M_AWADDR, then go to WRITE.
  - word_ready is 0 in all other states.
- WRITE: M_AWVALID and M_WVALID rise together on entry.
  - Each valid drops the cycle after its own handshake (AWVALID&&AWREADY, WVALID&&WREADY), so both simultaneous and independent readies are handled.
  - Once both handshakes are done, go to WRESP.
  - AWADDR and WDATA stay stable while their valid is high.
- WRESP: M_BREADY=1.
  - On BVALID, set error if BRESP != 0.
  - If idx == NUM_WORDS-1, go to RADDR. Otherwise increment idx and go to FETCH.
- RADDR: M_ARVALID=1, M_ARADDR=RESULT_ADDR, both held until ARREADY, then go to RDATA.
- RDATA: M_RREADY=1. The slave can spend many cycles computing before RVALID; there is no timeout.
  - On RVALID, capture prediction=M_RDATA[3:0] and set error if RRESP != 0, then go to FINISH.
- FINISH: done=1 for one cycle, then go to IDLE.
- Error responses do not abort the sequence. All NUM_WORDS writes and the read always complete.
- idx width is $clog2(NUM_WORDS). Address arithmetic is zero-extended to ADDRESS bits.

## Timing
- Reset values: every *VALID, BREADY, RREADY, word_ready, busy, done and error are 0. prediction, AWADDR, WDATA and ARADDR are 0. WSTRB is 4'hF.
- Reset is asserted asynchronously and released synchronously. Asserting rst mid-transaction drops all valids/readies in the same cycle and returns to IDLE; no partial state is retained.
- All outputs are registered. No combinational path from any input to any output.
- Zero-wait slave, per word: FETCH 1 cycle, WRITE 1 cycle, WRESP 1 cycle, i.e. 3 cycles per word.
- Zero-wait slave, read: RADDR 1 cycle, RDATA 1 cycle, FINISH 1 cycle.
- Minimum start-to-done is 3*NUM_WORDS+3 cycles, which is 75 at the defaults.
- done rises the cycle after the R handshake. prediction is valid in that same cycle.
- busy falls the cycle after done.

## Test plan
- Zero-wait responder, words 0x1000_0000+n, start → 24 writes to 0x00..0x5C with matching WDATA and WSTRB=F, then read of 0x60. RDATA=7 → prediction=7, done one cycle at cycle 75, error=0.
- Against axi4_lite_slave + NeuralNetwork → slave register[n] equals the written words, and done follows the slave's compute latency.
- AWREADY 3 cycles before WREADY on every write → each valid drops individually after its own handshake. No duplicate writes; address/data stable while valid.
- BRESP=2'b10 on write 5 only → all remaining writes and the read still occur, error=1 at done. The next start clears error to 0.
- word_valid low for 10 cycles before word 12, and a second start pulsed mid-sequence → FETCH stalls with no AW activity, and the second start is ignored.
- rst asserted during RDATA wait → all valids/readies 0 immediately, busy=0, prediction retains its reset value 0. A new start restarts at address 0x00.
